// File: rtl/sa_pkg.sv
// ============================================================================
// Module   : sa_pkg
// Brief    : Shared constants and helpers for the systolic-array result path.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sa_pkg;

    localparam int BF16_W = 16;

    // Occupancy needs one extra bit so that a completely full buffer (DEPTH) is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/result_fifo_ctrl.sv
// ============================================================================
// Module   : result_fifo_ctrl
// Brief    : Pointer, occupancy, full/empty and sticky-overflow control.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo_ctrl
    import sa_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic                          out_ready,
    output logic                          wr_en,
    output logic [$clog2(DEPTH)-1:0]      wr_ptr,
    output logic [$clog2(DEPTH)-1:0]      rd_ptr,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = count_width(DEPTH);

    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_overflow;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == c_CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = in_valid && !w_full;
    assign w_pop   = out_ready && !w_empty;

    // Pointers wrap on their own because DEPTH is a power of two.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else if (flush) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
            if (in_valid && w_full)
                r_overflow <= 1'b1;
        end
    end

    assign wr_en    = w_push && !flush;
    assign wr_ptr   = r_wr_ptr;
    assign rd_ptr   = r_rd_ptr;
    assign count    = r_count;
    assign full     = w_full;
    assign empty    = w_empty;
    assign overflow = r_overflow;

endmodule

`default_nettype wire

// File: rtl/result_fifo.sv
// ============================================================================
// Module   : result_fifo
// Brief    : DEPTH-entry result FIFO with valid/ready handshake and overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_fifo
    import sa_pkg::*;
#(
    parameter int WIDTH = BF16_W,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          clr,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          empty,
    output logic                          overflow
);

    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_wr_en;
    logic [c_AW-1:0]  w_wr_ptr;
    logic [c_AW-1:0]  w_rd_ptr;
    logic             w_full;
    logic             w_empty;

    result_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .out_ready (out_ready),
        .wr_en     (w_wr_en),
        .wr_ptr    (w_wr_ptr),
        .rd_ptr    (w_rd_ptr),
        .count     (count),
        .full      (w_full),
        .empty     (w_empty),
        .overflow  (overflow)
    );

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[w_wr_ptr] <= in_data;
        end
    end

    // Stale entries stay in the array after a pop or flush, so the read port is gated when empty.
    assign out_data  = w_empty ? '0 : r_mem[w_rd_ptr];
    assign out_valid = !w_empty;
    assign in_ready  = !w_full;
    assign full      = w_full;
    assign empty     = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_result_fifo.sv
// ============================================================================
// Module   : tb_result_fifo
// Brief    : Directed self-checking bench for result_fifo (WIDTH=16, DEPTH=4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_fifo;

    logic        clk = 1'b0;
    logic        clr;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [2:0]  count;
    logic        full;
    logic        empty;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    result_fifo #(
        .WIDTH (16),
        .DEPTH (4)
    ) dut (
        .clk       (clk),
        .clr       (clr),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int     accepted;
        logic [15:0] fill_vals [4];
        fill_vals[0] = 16'h3F80;
        fill_vals[1] = 16'h4000;
        fill_vals[2] = 16'h4040;
        fill_vals[3] = 16'h4080;

        clr = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        #12;
        check("rst_in_ready",  in_ready,  1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data",  out_data,  0);
        check("rst_count",     count,     0);
        check("rst_full",      full,      0);
        check("rst_empty",     empty,     1);
        check("rst_overflow",  overflow,  0);
        @(negedge clk);
        clr = 1'b0;

        // Fill and drain in order
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = fill_vals[i];
            tick();
            check("fill_count", count, i + 1);
            check("fill_head", out_data, 16'h3F80);
        end
        check("fill_full", full, 1);
        check("fill_in_ready", in_ready, 0);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", out_data, fill_vals[i]);
            check("drain_valid", out_valid, 1);
            tick();
        end
        check("drain_empty", empty, 1);
        check("drain_zero", out_data, 0);

        // Simultaneous push/pop at count=2, pointers wrap several times
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 16'h0001; tick();
        in_data = 16'h0002; tick();
        check("pp_start_count", count, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'(i + 3);
            check("pp_head", out_data, i + 1);
            tick();
            check("pp_count", count, 2);
        end
        in_valid = 1'b0;
        check("pp_tail0", out_data, 16'd11); tick();
        check("pp_tail1", out_data, 16'd12); tick();
        check("pp_empty", empty, 1);

        // Overflow while full
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'(16'h1000 + i);
            tick();
        end
        check("ov_full_count", count, 4);
        in_data = 16'hBF80; out_ready = 1'b1;
        tick();
        check("ov_flag", overflow, 1);
        check("ov_count", count, 3);
        check("ov_head", out_data, 16'h1001);
        out_ready = 1'b0; in_data = 16'h2000;
        check("ov_ready_after_pop", in_ready, 1);
        tick();
        check("ov_refill_count", count, 4);
        in_valid = 1'b0; out_ready = 1'b1;
        check("ov_d0", out_data, 16'h1001); tick();
        check("ov_d1", out_data, 16'h1002); tick();
        check("ov_d2", out_data, 16'h1003); tick();
        check("ov_d3", out_data, 16'h2000); tick();
        check("ov_drained", empty, 1);
        check("ov_sticky", overflow, 1);

        // Flush during push and pop at count=3
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'(16'h3001 + i);
            tick();
        end
        check("fl_pre_count", count, 3);
        flush = 1'b1; in_data = 16'hDEAD; out_ready = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("fl_count", count, 0);
        check("fl_empty", empty, 1);
        check("fl_overflow", overflow, 0);
        check("fl_out_data", out_data, 0);
        in_valid = 1'b1; in_data = 16'h4444;
        tick();
        in_valid = 1'b0;
        check("fl_after_push", out_data, 16'h4444);
        check("fl_after_count", count, 1);
        out_ready = 1'b1; tick();
        check("fl_after_empty", empty, 1);

        // Back-pressure: consumer stalled for 6 cycles
        out_ready = 1'b0; in_valid = 1'b1; accepted = 0;
        for (int i = 0; i < 6; i++) begin
            in_data = 16'(16'h5000 + i);
            if (in_ready) accepted++;
            tick();
            check("bp_hold", out_data, 16'h5000);
        end
        in_valid = 1'b0;
        check("bp_accepted", accepted, 4);
        check("bp_count", count, 4);
        check("bp_full", full, 1);
        check("bp_overflow", overflow, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("bp_drain", out_data, 16'h5000 + i);
            tick();
        end
        check("bp_empty", empty, 1);

        // Asynchronous clear mid-cycle at count=3
        out_ready = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 16'(16'h6000 + i);
            tick();
        end
        in_valid = 1'b0;
        check("clr_pre_count", count, 3);
        #2;
        clr = 1'b1;
        #1;
        check("clr_count", count, 0);
        check("clr_empty", empty, 1);
        check("clr_out_data", out_data, 0);
        check("clr_overflow", overflow, 0);
        check("clr_in_ready", in_ready, 1);
        @(negedge clk);
        clr = 1'b0;
        in_valid = 1'b1; in_data = 16'h7777;
        tick();
        in_valid = 1'b0;
        check("clr_first_push", out_data, 16'h7777);
        check("clr_first_count", count, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/result_fifo.md
# result_fifo

Parametrised result buffer that follows the single-word result register. It queues completed BFLOAT16 (or wider) results from the multiplier/PE output stage in a DEPTH-entry first-in-first-out store. The downstream drain logic reads them out over a valid/ready handshake. It sits between the systolic array result outputs and the readout/writeback path, and adds back-pressure, occupancy reporting and overflow detection.

## Interface
- WIDTH, 16: result word width in bits; 16 matches BFLOAT16.
- DEPTH, 4: number of entries. Must be a power of two, minimum 2.
- clk  input  1  clock; all state changes on the rising edge.
- clr  input  1  reset; asynchronous, active-high; clears all state.
- flush  input  1  synchronous empty; active-high.
- in_valid  input  1  producer has a result on in_data.
- in_data  input  WIDTH  result word.
- in_ready  output  1  buffer accepts a word this cycle; equals !full.
- out_valid  output  1  out_data holds the oldest stored word; equals !empty.
- out_data  output  WIDTH  oldest word; forced to 0 when empty.
- out_ready  input  1  consumer takes out_data this cycle.
- count  output  $clog2(DEPTH)+1  number of stored words, 0..DEPTH.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- overflow  output  1  sticky flag: a push was attempted while full.

## Operation
- Storage is a DEPTH x WIDTH register array.
- Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH. count is a separate counter.
- push = in_valid && in_ready. pop = out_valid && out_ready.
- On push, in_data is written at wr_ptr and wr_ptr increments.
- On pop, rd_ptr increments.
- count update:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on both, or on neither.
- Simultaneous push and pop with 1 <= count < DEPTH: both happen and count is unchanged.
- Empty: in_ready = 1 and a push is accepted.
- Full: in_ready = 0 even if out_ready = 1. There is no same-cycle pass-through; the freed slot is usable next cycle.
- A pop while empty is impossible because out_valid = 0. out_ready is ignored in that case.
- overflow sets on any cycle with in_valid && full && !flush. It holds until clr or flush.
- flush has priority over push and pop in the same cycle:
  - pointers and count go to 0, overflow goes to 0;
  - any concurrent push is dropped, any concurrent pop is void;
  - array contents are not cleared.
- clr asserted at any time, including mid-transfer, takes effect immediately:
  - pointers, count and overflow go to 0;
  - all array entries go to 0;
  - outputs take their reset values without waiting for a clock edge.
- Reset values: in_ready=1, out_valid=0, out_data=0, count=0, full=0, empty=1, overflow=0.

## Timing
- All outputs are derived from registered state only. There is no combinational path from in_valid or out_ready to any output.
- Write-to-read latency is 1 cycle. A word pushed at edge N is on out_data with out_valid=1 after edge N, when the buffer was empty.
- Throughput is one push and one pop per cycle.
- Fill: after DEPTH consecutive pushes with no pops, full=1 and in_ready=0 from the following cycle.
- A pop at edge N updates out_data to the next entry, or to 0 if the buffer becomes empty, immediately after edge N.
- Deasserting clr: the first push is accepted on the first rising edge after deassertion.

## Structure
- Shared package sa_pkg holds:
  - BF16_W = 16, used as the WIDTH default;
  - the function or constant for the count width, $clog2(DEPTH)+1.
- One sub-module is natural: result_fifo_ctrl. It holds the pointers, count, full/empty and overflow logic.
- The top level holds the register array and the output zero-gating.
- No other sub-modules.

## Test plan
- Reset/idle: assert clr mid-run with count=3.
  - Required: count=0, empty=1, out_data=0, overflow=0 immediately, with no clock edge needed.
- Fill and drain in order (DEPTH=4): push 0x3F80, 0x4000, 0x4040, 0x4080.
  - Required: full=1, in_ready=0.
  - Then hold out_ready=1: out_data sequence 0x3F80, 0x4000, 0x4040, 0x4080, then empty=1 and out_data=0.
- Simultaneous push/pop at count=2 for 10 cycles.
  - Required: count stays 2, output order is preserved, and the pointers wrap past index 3 correctly.
- Overflow while full: in_valid=1 with in_data=0xBF80 and out_ready=1.
  - Required: the word is not stored, overflow=1 and stays 1 after later pops; count goes 4 then 3.
  - A push is accepted on the cycle after the pop.
- Flush during push and pop at count=3.
  - Required: next cycle count=0, empty=1, overflow=0.
  - The dropped push word never appears on out_data.
- Back-pressure: out_ready=0 for 6 cycles while in_valid=1.
  - Required: exactly 4 words are accepted and out_data holds the first word stable throughout.
